// File: rtl/io_pkg.sv
// Shared definitions for the processor OUT-port capture FIFO.
//   DATA_W        : width of the processor OUT bus
//   DEFAULT_DEPTH : default number of FIFO entries
//   occ_w()       : width of an occupancy counter able to hold 0..depth
package io_pkg;

    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 8;

    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/out_port_fifo_if.sv
// Bus bundle between the processor OUT port / consumer and out_port_fifo.
//   proc_out, proc_wr, ovf_clr : producer side (into the FIFO)
//   dout, dout_valid, dout_ready : consumer valid/ready handshake
//   count, full, overflow : status
// master = producer/consumer side, slave = the FIFO.
interface out_port_fifo_if #(
    parameter int DEPTH = io_pkg::DEFAULT_DEPTH
);
    import io_pkg::*;

    logic [DATA_W-1:0]       proc_out;
    logic                    proc_wr;
    logic                    ovf_clr;
    logic [DATA_W-1:0]       dout;
    logic                    dout_valid;
    logic                    dout_ready;
    logic [occ_w(DEPTH)-1:0] count;
    logic                    full;
    logic                    overflow;

    modport master (
        output proc_out, proc_wr, ovf_clr, dout_ready,
        input  dout, dout_valid, count, full, overflow
    );

    modport slave (
        input  proc_out, proc_wr, ovf_clr, dout_ready,
        output dout, dout_valid, count, full, overflow
    );

endinterface

// File: rtl/out_port_fifo_mem.sv
// DEPTH x DATA_W storage for out_port_fifo.
//   clk   : write clock
//   we    : write enable, waddr/wdata written on rising clk
//   raddr : asynchronous read address, rdata = mem[raddr]
module fifo_mem_8
    import io_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    // Contents are not reset: the read side is gated by occupancy.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// First-word-fall-through FIFO capturing the processor OUT port.
//   clk   : system clock
//   reset : synchronous, active-low; flushes all entries
//   bus   : out_port_fifo_if.slave (capture inputs, valid/ready output, status)
// CAPTURE_ON_CHANGE=1 captures whenever proc_out differs from the last value
// seen; CAPTURE_ON_CHANGE=0 captures on every proc_wr strobe.
module out_port_fifo
    import io_pkg::*;
#(
    parameter int DEPTH             = DEFAULT_DEPTH,
    parameter bit CAPTURE_ON_CHANGE = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    out_port_fifo_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = occ_w(DEPTH);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] last_out_q, last_out_d;

    logic              cap;
    logic              push;
    logic              pop;
    logic              drop;
    logic [DATA_W-1:0] rdata;

    fifo_mem_8 #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.proc_out),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    always_comb begin
        cap        = CAPTURE_ON_CHANGE ? (bus.proc_out != last_out_q) : bus.proc_wr;
        pop        = valid_q & bus.dout_ready;
        // When full, a same-cycle pop frees the slot at rd_ptr == wr_ptr,
        // so the new value may be written there.
        push       = cap & (~full_q | pop);
        drop       = cap & full_q & ~pop;

        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

        // Status flags are derived from the next count, not pointer compare,
        // since rd_ptr == wr_ptr is ambiguous between empty and full.
        full_d     = (count_d == CNT_W'(DEPTH));
        valid_d    = (count_d != '0);

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d      = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        // Track every value seen, accepted or not, so a steady value is
        // captured exactly once.
        last_out_d = bus.proc_out;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            last_out_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            last_out_q <= last_out_d;
        end
    end

    // Storage is not reset, so gate the read data to a known zero when empty.
    assign bus.dout       = valid_q ? rdata : '0;
    assign bus.dout_valid = valid_q;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_out_port_fifo.sv
module tb_out_port_fifo;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    out_port_fifo_if #(.DEPTH(DEPTH)) bc ();
    out_port_fifo_if #(.DEPTH(DEPTH)) bs ();

    out_port_fifo #(.DEPTH(DEPTH), .CAPTURE_ON_CHANGE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .bus(bc)
    );
    out_port_fifo #(.DEPTH(DEPTH), .CAPTURE_ON_CHANGE(1'b0)) dut_s (
        .clk(clk), .reset(reset), .bus(bs)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a queue per DUT plus the last-seen value and the sticky flag.
    logic [7:0] mq_c[$];
    logic [7:0] mq_s[$];
    logic [7:0] ml_c;
    logic       mo_c, mo_s;

    // Values the consumer actually took from each DUT.
    logic [7:0] log_c[$];
    logic [7:0] log_s[$];

    always @(posedge clk) begin
        if (!reset) begin
            mq_c.delete(); mq_s.delete();
            ml_c = 8'h00; mo_c = 1'b0; mo_s = 1'b0;
        end else begin
            if (mq_c.size() > 0 && bc.dout_ready) void'(mq_c.pop_front());
            if (bc.ovf_clr) mo_c = 1'b0;
            if (bc.proc_out != ml_c) begin
                if (mq_c.size() < DEPTH) mq_c.push_back(bc.proc_out);
                else mo_c = 1'b1;
            end
            ml_c = bc.proc_out;

            if (mq_s.size() > 0 && bs.dout_ready) void'(mq_s.pop_front());
            if (bs.ovf_clr) mo_s = 1'b0;
            if (bs.proc_wr) begin
                if (mq_s.size() < DEPTH) mq_s.push_back(bs.proc_out);
                else mo_s = 1'b1;
            end
        end
    end

    task automatic cmp(input string nm, input logic v, input logic [7:0] d, input int c,
                       input logic f, input logic o, input int sz, input logic [7:0] hd,
                       input logic mo);
        logic ok;
        ok = (v === (sz > 0)) && (c == sz) && (f === (sz == DEPTH)) && (o === mo)
             && (sz == 0 || d === hd);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s t=%0t got v=%0b d=%02h c=%0d f=%0b o=%0b want v=%0b d=%02h c=%0d f=%0b o=%0b",
                      nm, $time, v, d, c, f, o, sz > 0, hd, sz, sz == DEPTH, mo);
    endtask

    // Sample mid-low-phase: outputs settled, inputs for the next edge already applied.
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            cmp("model_chg", bc.dout_valid, bc.dout, int'(bc.count), bc.full, bc.overflow,
                mq_c.size(), (mq_c.size() > 0) ? mq_c[0] : 8'h00, mo_c);
            cmp("model_stb", bs.dout_valid, bs.dout, int'(bs.count), bs.full, bs.overflow,
                mq_s.size(), (mq_s.size() > 0) ? mq_s[0] : 8'h00, mo_s);
            if (bc.dout_valid && bc.dout_ready) log_c.push_back(bc.dout);
            if (bs.dout_valid && bs.dout_ready) log_s.push_back(bs.dout);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic check_log(input string nm, input bit strobe, input logic [7:0] e[$]);
        logic [7:0] got[$];
        got = strobe ? log_s : log_c;
        check({nm, "_len"}, got.size(), e.size());
        for (int i = 0; i < e.size() && i < got.size(); i++)
            check($sformatf("%s_%0d", nm, i), int'(got[i]), int'(e[i]));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        logic [7:0] e[$];
        logic [7:0] seq[$];

        reset = 1'b0;
        bc.proc_out = 8'h00; bc.proc_wr = 1'b0; bc.ovf_clr = 1'b0; bc.dout_ready = 1'b0;
        bs.proc_out = 8'h00; bs.proc_wr = 1'b0; bs.ovf_clr = 1'b0; bs.dout_ready = 1'b0;
        tick(2);
        chk_en = 1'b1;
        reset  = 1'b1;
        check("rst_count", int'(bc.count), 0);
        check("rst_valid", int'(bc.dout_valid), 0);
        check("rst_full", int'(bc.full), 0);
        check("rst_ovf", int'(bc.overflow), 0);
        check("rst_dout", int'(bc.dout), 8'h00);

        // Reset flush
        bc.proc_out = 8'h11; tick(1);
        bc.proc_out = 8'h22; tick(1);
        bc.proc_out = 8'h33; tick(1);
        check("pre_flush_count", int'(bc.count), 3);
        check("pre_flush_head", int'(bc.dout), 8'h11);
        reset = 1'b0; bc.proc_out = 8'h00; tick(1);
        reset = 1'b1; tick(3);
        check("flush_count", int'(bc.count), 0);
        check("flush_valid", int'(bc.dout_valid), 0);
        check("flush_ovf", int'(bc.overflow), 0);

        // Change capture
        seq = '{8'h00, 8'h05, 8'h05, 8'h05, 8'h07, 8'h07, 8'h00};
        foreach (seq[i]) begin
            bc.proc_out = seq[i];
            tick(1);
        end
        check("chg_count", int'(bc.count), 3);
        log_c.delete();
        bc.dout_ready = 1'b1; tick(3); bc.dout_ready = 1'b0;
        e = '{8'h05, 8'h07, 8'h00};
        check_log("chg_drain", 1'b0, e);
        check("chg_empty", int'(bc.count), 0);

        // Fill and overflow; a clear coinciding with a drop leaves the flag set
        for (int i = 1; i <= 9; i++) begin
            bc.proc_out = 8'(i);
            tick(1);
        end
        check("fill_full", int'(bc.full), 1);
        check("fill_count", int'(bc.count), 8);
        check("fill_ovf", int'(bc.overflow), 1);
        bc.proc_out = 8'h0A; bc.ovf_clr = 1'b1; tick(1); bc.ovf_clr = 1'b0;
        check("ovf_set_wins", int'(bc.overflow), 1);
        log_c.delete();
        bc.dout_ready = 1'b1; tick(8); bc.dout_ready = 1'b0;
        e.delete();
        for (int i = 1; i <= 8; i++) e.push_back(8'(i));
        check_log("fill_drain", 1'b0, e);
        check("fill_ovf_sticky", int'(bc.overflow), 1);
        bc.ovf_clr = 1'b1; tick(1); bc.ovf_clr = 1'b0;
        check("ovf_clr", int'(bc.overflow), 0);

        // Full with simultaneous pop and capture
        for (int i = 1; i <= 8; i++) begin
            bc.proc_out = 8'(i);
            tick(1);
        end
        check("fpc_full_before", int'(bc.full), 1);
        log_c.delete();
        bc.dout_ready = 1'b1; bc.proc_out = 8'hAA; tick(1);
        check("fpc_count", int'(bc.count), 8);
        check("fpc_ovf", int'(bc.overflow), 0);
        tick(8); bc.dout_ready = 1'b0;
        e.delete();
        for (int i = 1; i <= 8; i++) e.push_back(8'(i));
        e.push_back(8'hAA);
        check_log("fpc_drain", 1'b0, e);
        check("fpc_empty", int'(bc.count), 0);

        // Wrap-around at occupancy 1..3
        log_c.delete();
        e.delete();
        for (int i = 0; i < 20; i++) begin
            bc.proc_out   = 8'h40 + 8'(i);
            bc.dout_ready = (i >= 2);
            e.push_back(8'h40 + 8'(i));
            tick(1);
        end
        tick(3); bc.dout_ready = 1'b0;
        check_log("wrap", 1'b0, e);
        check("wrap_empty", int'(bc.count), 0);

        // Strobe mode
        bs.proc_out = 8'h3C;
        repeat (3) begin
            bs.proc_wr = 1'b1; tick(1);
            bs.proc_wr = 1'b0; tick(1);
        end
        check("stb_count", int'(bs.count), 3);
        bs.proc_out = 8'h55; tick(2);
        check("stb_no_cap", int'(bs.count), 3);
        log_s.delete();
        bs.dout_ready = 1'b1; tick(4); bs.dout_ready = 1'b0;
        e = '{8'h3C, 8'h3C, 8'h3C};
        check_log("stb_drain", 1'b1, e);

        tick(1);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
